// File: rtl/histogram_sequencer.sv
// histogram_sequencer: per-frame controller that clears the projection
// histogram, raster-scans the 1-bit frame buffer and collects the readout.
module histogram_sequencer #(
    parameter int IMWIDTH  = 240,
    parameter int IMHEIGHT = 180,
    parameter int TIMEOUT  = 1024,
    parameter int GUARD    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frameReady,
    output logic        busy,
    output logic        frameDone,
    output logic        error,
    output logic        fbRead,
    output logic [15:0] fbAddress,
    input  logic        fbStall,
    input  logic        fbData,
    output logic        histStart,
    output logic        histClear,
    output logic        histRead,
    output logic        histDone,
    output logic [7:0]  histXAddress,
    output logic [7:0]  histYAddress,
    output logic        histPixel,
    input  logic        histClearAck,
    input  logic        histXValid,
    input  logic        histYValid,
    output logic [7:0]  xReadCount,
    output logic [7:0]  yReadCount
);

    localparam int TLOG = $clog2(TIMEOUT + GUARD + 1);
    localparam int TW   = (TLOG < 10) ? 10 : TLOG + 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GUARD - 1);
    localparam logic [TW-1:0] ACK_IGNORE = TW'(2);
    localparam logic [7:0]    XMAX   = 8'(IMWIDTH - 1);
    localparam logic [7:0]    YMAX   = 8'(IMHEIGHT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_CLEAR_WAIT,
        S_START,
        S_SCAN,
        S_DRAIN,
        S_DONE,
        S_READ,
        S_READ_WAIT,
        S_GUARD_WAIT
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [7:0]      x_q, y_q;
    logic [7:0]      x_d, y_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      xcnt_q, ycnt_q;
    logic [7:0]      xcnt_d, ycnt_d;
    logic            error_q;
    logic            frameDone_q;
    logic            histClear_q, histStart_q;
    logic            histDone_q, histRead_q;
    logic            rdValid_q;
    logic [7:0]      xD_q, yD_q;
    logic            rd_s;
    logic            last_px;

    // A read goes out in every unstalled SCAN cycle.
    assign rd_s    = (state_q == S_SCAN) && !fbStall;
    assign last_px = (x_q == XMAX) && (y_q == YMAX);

    // Raster and readout counter next values.
    always_comb begin
        x_d    = x_q + 8'd1;
        y_d    = y_q;
        addr_d = addr_q + 16'd1;
        if (x_q == XMAX) begin
            x_d = 8'd0;
            y_d = y_q + 8'd1;
        end
        xcnt_d = xcnt_q;
        ycnt_d = ycnt_q;
        if (histXValid && xcnt_q != 8'hFF) begin
            xcnt_d = xcnt_q + 8'd1;
        end
        if (histYValid && ycnt_q != 8'hFF) begin
            ycnt_d = ycnt_q + 8'd1;
        end
    end

    // Frame sequencing FSM with registered command pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            xcnt_q      <= '0;
            ycnt_q      <= '0;
            error_q     <= 1'b0;
            frameDone_q <= 1'b0;
            histClear_q <= 1'b0;
            histStart_q <= 1'b0;
            histDone_q  <= 1'b0;
            histRead_q  <= 1'b0;
        end else begin
            histClear_q <= 1'b0;
            histStart_q <= 1'b0;
            histDone_q  <= 1'b0;
            histRead_q  <= 1'b0;
            frameDone_q <= 1'b0;
            timer_q     <= timer_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (frameReady) begin
                        error_q     <= 1'b0;
                        xcnt_q      <= '0;
                        ycnt_q      <= '0;
                        x_q         <= '0;
                        y_q         <= '0;
                        addr_q      <= '0;
                        histClear_q <= 1'b1;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    timer_q <= '0;
                    state_q <= S_CLEAR_WAIT;
                end
                S_CLEAR_WAIT: begin
                    if (timer_q >= ACK_IGNORE && histClearAck) begin
                        timer_q     <= '0;
                        histStart_q <= 1'b1;
                        state_q     <= S_START;
                    end else if (timer_q == T_LAST) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    state_q <= S_SCAN;
                end
                S_SCAN: begin
                    if (!fbStall) begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        addr_q <= addr_d;
                        if (last_px) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    timer_q    <= '0;
                    histDone_q <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    if (timer_q[0]) begin
                        timer_q    <= '0;
                        histRead_q <= 1'b1;
                        state_q    <= S_READ;
                    end
                end
                S_READ: begin
                    timer_q <= '0;
                    state_q <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    xcnt_q <= xcnt_d;
                    ycnt_q <= ycnt_d;
                    if (!histXValid && !histYValid && xcnt_q != 8'd0) begin
                        timer_q <= '0;
                        state_q <= S_GUARD_WAIT;
                    end else if (timer_q == T_LAST) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_GUARD_WAIT: begin
                    if (timer_q == G_LAST) begin
                        frameDone_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel data returns one cycle after its read; align bin addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdValid_q <= 1'b0;
            xD_q      <= '0;
            yD_q      <= '0;
        end else begin
            rdValid_q <= rd_s;
            if (rd_s) begin
                xD_q <= x_q;
                yD_q <= y_q;
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign frameDone    = frameDone_q;
    assign error        = error_q;
    assign fbRead       = rd_s;
    assign fbAddress    = addr_q;
    assign histStart    = histStart_q;
    assign histClear    = histClear_q;
    assign histRead     = histRead_q;
    assign histDone     = histDone_q;
    assign histXAddress = xD_q;
    assign histYAddress = yD_q;
    assign histPixel    = fbData & rdValid_q;
    assign xReadCount   = xcnt_q;
    assign yReadCount   = ycnt_q;

endmodule

// File: tb/tb_histogram_sequencer.sv
// tb_histogram_sequencer: frame-level bench with a histogram block model
// and a read-to-pixel scoreboard.
module tb_histogram_sequencer;

    localparam int W  = 12;
    localparam int H  = 8;
    localparam int TO = 40;
    localparam int GD = 4;

    logic        clk;
    logic        reset;
    logic        frameReady;
    logic        busy, frameDone, error;
    logic        fbRead;
    logic [15:0] fbAddress;
    logic        fbStall, fbData;
    logic        histStart, histClear, histRead, histDone;
    logic [7:0]  histXAddress, histYAddress;
    logic        histPixel;
    logic        histClearAck, histXValid, histYValid;
    logic [7:0]  xReadCount, yReadCount;

    histogram_sequencer #(
        .IMWIDTH(W), .IMHEIGHT(H), .TIMEOUT(TO), .GUARD(GD)
    ) dut (
        .clk(clk), .reset(reset), .frameReady(frameReady),
        .busy(busy), .frameDone(frameDone), .error(error),
        .fbRead(fbRead), .fbAddress(fbAddress),
        .fbStall(fbStall), .fbData(fbData),
        .histStart(histStart), .histClear(histClear),
        .histRead(histRead), .histDone(histDone),
        .histXAddress(histXAddress), .histYAddress(histYAddress),
        .histPixel(histPixel), .histClearAck(histClearAck),
        .histXValid(histXValid), .histYValid(histYValid),
        .xReadCount(xReadCount), .yReadCount(yReadCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pat;
        int stall;
        int extra;
        int exp_fb;
        int exp_xrc;
        int exp_yrc;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int p;
    } sb_t;

    vec_t vecs[5];
    sb_t  sbq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit pend_reset, pend_ready, ack_mode, err_prev;
    int stall_pct, cur_pat, extra_at;
    int xv_rem, yv_rem;
    int exp_x, exp_y, exp_addr;
    int n_clear, n_start, n_done, n_read, n_fd, n_fb;
    int clear_cyc, start_cyc, done_cyc, read_cyc, fd_cyc, err_cyc;
    int xbin[W];
    int ybin[H];

    function automatic int pix(int pat, int x, int y);
        case (pat)
            0: return 1;
            1: return (x == y) ? 1 : 0;
            2: return (x + y) % 2;
            3: return 0;
            default: return ((3 * x + y) % 5 == 0) ? 1 : 0;
        endcase
    endfunction

    function automatic int exp_xbin(int pat, int k);
        int s = 0;
        for (int y = 0; y < H; y++) s += pix(pat, k, y);
        return s & 255;
    endfunction

    function automatic int exp_ybin(int pat, int k);
        int s = 0;
        for (int x = 0; x < W; x++) s += pix(pat, x, k);
        return s & 255;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     name, act, expv, cyc);
        end
    endtask

    task automatic sample();
        sb_t e;
        int  ncmd;
        if (reset) begin
            sbq.delete();
            xv_rem = 0;
            yv_rem = 0;
            return;
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("hist_x_addr", int'(histXAddress), e.x);
            chk("hist_y_addr", int'(histYAddress), e.y);
            chk("hist_pixel", int'(histPixel), e.p);
        end else begin
            chk("pixel_no_read", int'(histPixel), 0);
        end
        ncmd = int'(histClear) + int'(histStart) +
               int'(histDone) + int'(histRead);
        if (ncmd > 0) chk("cmd_onehot", ncmd, 1);
        if (histClear) begin
            n_clear++;
            clear_cyc = cyc;
            chk("error_cleared", int'(error), 0);
            for (int k = 0; k < W; k++) xbin[k] = 0;
            for (int k = 0; k < H; k++) ybin[k] = 0;
            exp_x = 0;
            exp_y = 0;
            exp_addr = 0;
        end
        if (histStart) begin
            n_start++;
            start_cyc = cyc;
        end
        if (histDone) begin
            n_done++;
            done_cyc = cyc;
            chk("pixel_in_done", int'(histPixel), 0);
        end
        if (histRead) begin
            n_read++;
            read_cyc = cyc;
            xv_rem = W;
            yv_rem = H;
        end
        if (histPixel) begin
            if (int'(histXAddress) < W)
                xbin[histXAddress] = (xbin[histXAddress] + 1) & 255;
            if (int'(histYAddress) < H)
                ybin[histYAddress] = (ybin[histYAddress] + 1) & 255;
        end
        if (frameDone) begin
            n_fd++;
            fd_cyc = cyc;
        end
        if (error && !err_prev) err_cyc = cyc;
        err_prev = error;
        if (fbRead) begin
            n_fb++;
            chk("read_while_stall", int'(fbStall), 0);
            chk("fb_address", int'(fbAddress), exp_addr);
            e.x = exp_x;
            e.y = exp_y;
            e.p = pix(cur_pat, exp_x, exp_y);
            sbq.push_back(e);
            exp_addr++;
            exp_x++;
            if (exp_x == W) begin
                exp_x = 0;
                exp_y++;
            end
            if (extra_at >= 0 && n_fb == extra_at) pend_ready = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reset      = pend_reset;
        frameReady = pend_ready;
        pend_ready = 1'b0;
        fbStall    = (stall_pct > 0) &&
                     (int'($urandom_range(99, 0)) < stall_pct);
        if (sbq.size() > 0) fbData = (sbq[0].p != 0);
        else fbData = ($urandom_range(1, 0) != 0);
        histClearAck = ack_mode;
        histXValid   = (xv_rem > 0);
        histYValid   = (yv_rem > 0);
        if (xv_rem > 0) xv_rem--;
        if (yv_rem > 0) yv_rem--;
        @(negedge clk);
        cyc++;
        sample();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, int'({busy, frameDone, error, fbRead,
            histStart, histClear, histRead, histDone, histPixel}), 0);
        chk({tag, "_fbaddr"}, int'(fbAddress), 0);
        chk({tag, "_xaddr"}, int'(histXAddress), 0);
        chk({tag, "_yaddr"}, int'(histYAddress), 0);
        chk({tag, "_xrc"}, int'(xReadCount), 0);
        chk({tag, "_yrc"}, int'(yReadCount), 0);
    endtask

    task automatic start_frame(input int pat, input int stall,
                               input int extra);
        cur_pat   = pat;
        stall_pct = stall;
        extra_at  = extra;
        n_clear = 0; n_start = 0; n_done = 0;
        n_read  = 0; n_fd = 0; n_fb = 0;
        pend_ready = 1'b1;
    endtask

    task automatic run_frame(input vec_t v);
        ack_mode = 1'b1;
        start_frame(v.pat, v.stall, v.extra);
        for (int i = 0; i < 8 * W * H + 400 && n_fd == 0; i++) step();
        chk("frame_done", n_fd, 1);
        chk("frame_error", int'(error), 0);
        chk("n_clear", n_clear, 1);
        chk("n_start", n_start, 1);
        chk("n_done", n_done, 1);
        chk("n_read", n_read, 1);
        chk("n_fbread", n_fb, v.exp_fb);
        chk("x_read_count", int'(xReadCount), v.exp_xrc);
        chk("y_read_count", int'(yReadCount), v.exp_yrc);
        chk("clear_to_start", start_cyc - clear_cyc, 4);
        chk("done_to_read", read_cyc - done_cyc, 2);
        chk("read_to_fdone", fd_cyc - read_cyc, W + 2 + GD);
        for (int k = 0; k < W; k++)
            chk($sformatf("xbin%0d", k), xbin[k], exp_xbin(v.pat, k));
        for (int k = 0; k < H; k++)
            chk($sformatf("ybin%0d", k), ybin[k], exp_ybin(v.pat, k));
        stall_pct = 0;
        for (int i = 0; i < 8; i++) step();
        chk("idle_after", int'(busy), 0);
        chk("single_fdone", n_fd, 1);
        chk("single_clear", n_clear, 1);
    endtask

    initial begin
        bit hit;
        vecs[0] = '{0,  0, -1, W * H, W, H};
        vecs[1] = '{1, 30, -1, W * H, W, H};
        vecs[2] = '{2, 50, 40, W * H, W, H};
        vecs[3] = '{4, 10, -1, W * H, W, H};
        vecs[4] = '{3, 20, -1, W * H, W, H};

        reset = 1'b1; frameReady = 1'b0; fbStall = 1'b0; fbData = 1'b0;
        histClearAck = 1'b0; histXValid = 1'b0; histYValid = 1'b0;
        pend_reset = 1'b1; pend_ready = 1'b0; ack_mode = 1'b1;
        err_prev = 1'b0; stall_pct = 0; cur_pat = 0; extra_at = -1;
        xv_rem = 0; yv_rem = 0; exp_x = 0; exp_y = 0; exp_addr = 0;
        n_clear = 0; n_start = 0; n_done = 0; n_read = 0;
        n_fd = 0; n_fb = 0;
        clear_cyc = 0; start_cyc = 0; done_cyc = 0;
        read_cyc = 0; fd_cyc = 0; err_cyc = 0;

        for (int i = 0; i < 3; i++) step();
        check_zero("in_reset");
        pend_reset = 1'b0;
        step();
        check_zero("after_reset");

        foreach (vecs[i]) run_frame(vecs[i]);

        ack_mode = 1'b0;
        start_frame(0, 0, -1);
        for (int i = 0; i < 4 * TO && !error; i++) step();
        chk("timeout_flag", int'(error), 1);
        chk("timeout_cycles", err_cyc - clear_cyc, TO + 1);
        chk("timeout_idle", int'(busy), 0);
        chk("timeout_no_start", n_start, 0);
        chk("timeout_no_fdone", n_fd, 0);
        for (int i = 0; i < 5; i++) step();
        chk("error_sticky", int'(error), 1);
        run_frame(vecs[0]);

        ack_mode = 1'b1;
        start_frame(0, 20, -1);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            step();
            if (fbRead && fbAddress == 16'd50) hit = 1'b1;
        end
        chk("reach_addr50", int'(hit), 1);
        pend_reset = 1'b1;
        step();
        pend_reset = 1'b0;
        step();
        check_zero("mid_scan_reset");
        n_clear = 0; n_start = 0;
        for (int i = 0; i < 4; i++) step();
        chk("no_pulse_after_reset", n_clear + n_start, 0);
        run_frame(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
